// File: rtl/clkdiv_align_ctrl.sv
// Reset/calibration sequencer for a Gowin CLKDIV in the deserializer clock path.
// Define CLKDIV_ALIGN_STATUS_EN to add the calib_count/relock_count status outputs.
module clkdiv_align_ctrl #(
  parameter int RST_HOLD   = 16,
  parameter int SETTLE     = 32,
  parameter int CHECK_LEN  = 8,
  parameter int CALIB_WAIT = 16,
  parameter int MAX_CALIB  = 8,
  parameter int LOSS_LEN   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       realign,
  input  logic       pattern_ok,
  output logic       div_resetn,
  output logic       div_calib,
  output logic       locked,
  output logic       fail,
  output logic       busy
`ifdef CLKDIV_ALIGN_STATUS_EN
  ,
  output logic [7:0] calib_count,
  output logic [7:0] relock_count
`endif
);

  localparam logic [2:0] ST_HOLD   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_CALIB  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_LOCKED = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  localparam logic [15:0] HOLD_LAST_C   = 16'(RST_HOLD - 1);
  localparam logic [15:0] SETTLE_LAST_C = 16'(SETTLE - 1);
  localparam logic [15:0] WAIT_LAST_C   = 16'(CALIB_WAIT - 1);
  localparam logic [15:0] CHECK_LEN_C   = 16'(CHECK_LEN);
  localparam logic [15:0] LOSS_LAST_C   = 16'(LOSS_LEN - 1);
  localparam logic [7:0]  MAX_CALIB_C   = 8'(MAX_CALIB);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d, timer_inc_s;
  logic [7:0]  attempts_q, attempts_d;
  logic        div_resetn_q, div_resetn_d;
  logic        div_calib_q, div_calib_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;

  assign timer_inc_s = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  // Next-state logic; the timer doubles as the consecutive-match and consecutive-loss counter.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_inc_s;
    attempts_d = attempts_q;
    if (realign) begin
      state_d    = ST_HOLD;
      timer_d    = 16'd0;
      attempts_d = 8'd0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          attempts_d = 8'd0;
          if (timer_q == HOLD_LAST_C) begin
            state_d = ST_SETTLE;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_inc_s;
          end
        end
        ST_SETTLE: begin
          if (timer_q == SETTLE_LAST_C) begin
            state_d = ST_CHECK;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_inc_s;
          end
        end
        ST_CHECK: begin
          if (timer_q == CHECK_LEN_C) begin
            state_d = ST_LOCKED;
            timer_d = 16'd0;
          end else if (!pattern_ok) begin
            timer_d = 16'd0;
            if (attempts_q < MAX_CALIB_C) begin
              state_d    = ST_CALIB;
              attempts_d = sat_inc8(attempts_q);
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            timer_d = timer_inc_s;
          end
        end
        ST_CALIB: begin
          state_d = ST_WAIT;
          timer_d = 16'd0;
        end
        ST_WAIT: begin
          if (timer_q == WAIT_LAST_C) begin
            state_d = ST_CHECK;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_inc_s;
          end
        end
        ST_LOCKED: begin
          if (pattern_ok) begin
            timer_d = 16'd0;
          end else if (timer_q == LOSS_LAST_C) begin
            // Realign in place: no divider reset, fresh attempt budget.
            state_d    = ST_CALIB;
            timer_d    = 16'd0;
            attempts_d = sat_inc8(8'd0);
          end else begin
            timer_d = timer_inc_s;
          end
        end
        ST_FAIL: begin
          timer_d = timer_q;
        end
        default: begin
          state_d    = ST_HOLD;
          timer_d    = 16'd0;
          attempts_d = 8'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    div_resetn_d = (state_d != ST_HOLD);
    div_calib_d  = (state_d == ST_CALIB);
    locked_d     = (state_d == ST_LOCKED);
    fail_d       = (state_d == ST_FAIL);
    busy_d       = (state_d != ST_LOCKED) && (state_d != ST_FAIL);
  end

  // State, timer, attempt counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_HOLD;
      timer_q      <= 16'd0;
      attempts_q   <= 8'd0;
      div_resetn_q <= 1'b0;
      div_calib_q  <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      attempts_q   <= attempts_d;
      div_resetn_q <= div_resetn_d;
      div_calib_q  <= div_calib_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
    end
  end

  assign div_resetn = div_resetn_q;
  assign div_calib  = div_calib_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign busy       = busy_q;

`ifdef CLKDIV_ALIGN_STATUS_EN
  logic [7:0] relock_q, relock_d;
  logic       relock_evt_s;

  assign relock_evt_s = (state_q == ST_LOCKED) && (state_d == ST_CALIB);

  // Loss-of-lock tally survives realign; only resetn clears it.
  always_comb begin
    if (relock_evt_s) begin
      relock_d = sat_inc8(relock_q);
    end else begin
      relock_d = relock_q;
    end
  end

  // Relock counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      relock_q <= 8'd0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign calib_count  = attempts_q;
  assign relock_count = relock_q;
`endif

endmodule

// File: tb/tb_clkdiv_align_ctrl.sv
// Self-checking bench for clkdiv_align_ctrl: vector table, directed corner sequences,
// and randomized pattern_ok/realign traffic checked against a behavioural model.
module tb_clkdiv_align_ctrl;

  localparam int RST_HOLD   = 16;
  localparam int SETTLE     = 32;
  localparam int CHECK_LEN  = 8;
  localparam int CALIB_WAIT = 16;
  localparam int MAX_CALIB  = 8;
  localparam int LOSS_LEN   = 4;
  localparam int LOCK_LAT   = RST_HOLD + SETTLE + CHECK_LEN + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic realign = 1'b0;
  logic pattern_ok = 1'b0;
  logic div_resetn, div_calib, locked, fail, busy;
`ifdef CLKDIV_ALIGN_STATUS_EN
  logic [7:0] calib_count, relock_count;
`endif
  logic [4:0] outs;
  assign outs = {div_resetn, div_calib, locked, fail, busy};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clkdiv_align_ctrl #(
    .RST_HOLD(RST_HOLD), .SETTLE(SETTLE), .CHECK_LEN(CHECK_LEN),
    .CALIB_WAIT(CALIB_WAIT), .MAX_CALIB(MAX_CALIB), .LOSS_LEN(LOSS_LEN)
  ) dut (
    .clk(clk), .resetn(resetn), .realign(realign), .pattern_ok(pattern_ok),
    .div_resetn(div_resetn), .div_calib(div_calib), .locked(locked),
    .fail(fail), .busy(busy)
`ifdef CLKDIV_ALIGN_STATUS_EN
    , .calib_count(calib_count), .relock_count(relock_count)
`endif
  );

  // Pulse monitor: counts div_calib cycles, flags short gaps and pulses while the divider is held.
  int pulses = 0;
  int viol = 0;
  int since_pulse = 1000;
  always @(negedge clk) begin
    if (div_calib) begin
      pulses <= pulses + 1;
      if (since_pulse < CALIB_WAIT + 1 || !div_resetn) viol <= viol + 1;
      since_pulse <= 1;
    end else begin
      since_pulse <= since_pulse + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ok);
    @(negedge clk);
    resetn = 1'b0;
    realign = 1'b0;
    pattern_ok = ok;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  // Behavioural reference: phases with absolute entry times and run lengths.
  typedef enum int {M_HOLD, M_SETTLE, M_CHECK, M_CALIB, M_WAIT, M_LOCKED, M_FAIL} mph_t;
  mph_t m_ph;
  int m_cyc, m_t0, m_run, m_tries, m_relock;

  task automatic m_reset();
    m_ph = M_HOLD; m_cyc = 0; m_t0 = 0; m_run = 0; m_tries = 0; m_relock = 0;
  endtask

  task automatic m_enter(input mph_t p);
    m_ph = p; m_t0 = m_cyc; m_run = 0;
  endtask

  task automatic model_step(input logic ok, input logic ra);
    m_cyc++;
    if (ra) begin
      m_enter(M_HOLD);
      m_tries = 0;
    end else begin
      case (m_ph)
        M_HOLD:   if (m_cyc - m_t0 >= RST_HOLD) m_enter(M_SETTLE);
        M_SETTLE: if (m_cyc - m_t0 >= SETTLE) m_enter(M_CHECK);
        M_CHECK: begin
          if (m_run >= CHECK_LEN) m_enter(M_LOCKED);
          else if (!ok) begin
            if (m_tries < MAX_CALIB) begin
              m_tries = (m_tries < 255) ? m_tries + 1 : 255;
              m_enter(M_CALIB);
            end else m_enter(M_FAIL);
          end else m_run++;
        end
        M_CALIB: m_enter(M_WAIT);
        M_WAIT:  if (m_cyc - m_t0 >= CALIB_WAIT) m_enter(M_CHECK);
        M_LOCKED: begin
          if (ok) m_run = 0;
          else begin
            m_run++;
            if (m_run >= LOSS_LEN) begin
              m_tries = 1;
              m_relock = (m_relock < 255) ? m_relock + 1 : 255;
              m_enter(M_CALIB);
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [4:0] m_outs();
    logic lk, fl;
    lk = (m_ph == M_LOCKED);
    fl = (m_ph == M_FAIL);
    return {m_ph != M_HOLD, m_ph == M_CALIB, lk, fl, !(lk || fl)};
  endfunction

  // Realign pulse, then expect a full RST_HOLD low period on div_resetn.
  task automatic realign_hold(input string name);
    int bad;
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check({name, "_rn_next"}, 32'(div_resetn), 32'd0);
    check({name, "_fail_next"}, 32'(fail), 32'd0);
    check({name, "_busy_next"}, 32'(busy), 32'd1);
    bad = 0;
    for (int k = 1; k < RST_HOLD; k++) begin
      tick();
      if (div_resetn !== 1'b0) bad++;
    end
    check({name, "_hold_low"}, 32'(bad), 32'd0);
    tick();
    check({name, "_hold_release"}, 32'(div_resetn), 32'd1);
  endtask

  typedef struct {
    int         cyc;
    logic [4:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int cur, n, p0, v0, bad;
    int regime;

    // {div_resetn, div_calib, locked, fail, busy} with pattern_ok held at 1
    vecs[0] = '{0,        5'b00001, "v_reset"};
    vecs[1] = '{1,        5'b00001, "v_hold1"};
    vecs[2] = '{15,       5'b00001, "v_hold15"};
    vecs[3] = '{16,       5'b10001, "v_release"};
    vecs[4] = '{17,       5'b10001, "v_settle"};
    vecs[5] = '{48,       5'b10001, "v_settle_end"};
    vecs[6] = '{56,       5'b10001, "v_prelock"};
    vecs[7] = '{LOCK_LAT, 5'b10100, "v_lock"};
    vecs[8] = '{58,       5'b10100, "v_lock58"};
    vecs[9] = '{120,      5'b10100, "v_lock_hold"};

    // Scenario 1: clean lock timeline
    do_reset(1'b1);
    p0 = pulses;
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      while (cur < vecs[i].cyc) begin
        tick();
        cur++;
      end
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end
    check("v_no_calib", 32'(pulses - p0), 32'd0);

    // Scenario 2: three calibration pulses then match
    do_reset(1'b0);
    p0 = pulses; v0 = viol; n = 0;
    while (pulses - p0 < 3 && n < 2000) begin tick(); n++; end
    check("s2_third_pulse_seen", 32'(div_calib), 32'd1);
    pattern_ok = 1'b1;
    n = 0;
    while (!locked && n < 300) begin tick(); n++; end
    check("s2_locked", 32'(locked), 32'd1);
    check("s2_fail", 32'(fail), 32'd0);
    check("s2_pulses", 32'(pulses - p0), 32'd3);
    check("s2_spacing", 32'(viol - v0), 32'd0);
`ifdef CLKDIV_ALIGN_STATUS_EN
    check("s2_calib_count", 32'(calib_count), 32'd3);
`endif

    // Scenario 3: never matches -> FAIL after MAX_CALIB pulses, then sticks
    do_reset(1'b0);
    p0 = pulses; v0 = viol; n = 0;
    while (!fail && n < 3000) begin tick(); n++; end
    check("s3_fail", 32'(fail), 32'd1);
    check("s3_locked", 32'(locked), 32'd0);
    check("s3_busy", 32'(busy), 32'd0);
    check("s3_pulses", 32'(pulses - p0), 32'(MAX_CALIB));
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (fail !== 1'b1 || busy !== 1'b0 || div_resetn !== 1'b1) bad++;
    end
    check("s3_stays_fail", 32'(bad), 32'd0);
    check("s3_no_more_pulses", 32'(pulses - p0), 32'(MAX_CALIB));
    check("s3_spacing", 32'(viol - v0), 32'd0);

    // Scenario 4: loss-of-lock filter
    do_reset(1'b1);
    n = 0;
    while (!locked && n < 200) begin tick(); n++; end
    check("s4_locked", 32'(locked), 32'd1);
    p0 = pulses;
    pattern_ok = 1'b0;
    repeat (LOSS_LEN - 1) tick();
    pattern_ok = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (locked !== 1'b1) bad++;
    end
    check("s4_short_loss_kept", 32'(bad), 32'd0);
    check("s4_short_loss_no_pulse", 32'(pulses - p0), 32'd0);
    pattern_ok = 1'b0;
    bad = 0;
    for (int k = 0; k < LOSS_LEN - 1; k++) begin
      tick();
      if (locked !== 1'b1) bad++;
    end
    check("s4_pre_loss", 32'(bad), 32'd0);
    tick();
    check("s4_loss_locked", 32'(locked), 32'd0);
    check("s4_loss_calib", 32'(div_calib), 32'd1);
    check("s4_loss_rn", 32'(div_resetn), 32'd1);
`ifdef CLKDIV_ALIGN_STATUS_EN
    check("s4_relock_count", 32'(relock_count), 32'd1);
    check("s4_calib_count", 32'(calib_count), 32'd1);
`endif
    tick();
    check("s4_pulse_single", 32'(div_calib), 32'd0);
    pattern_ok = 1'b1;
    n = 0;
    while (!locked && n < 200) begin tick(); n++; end
    check("s4_relocked", 32'(locked), 32'd1);

    // Scenario 5: realign from CALIB_WAIT, from FAIL, and on the final CHECK cycle
    do_reset(1'b0);
    p0 = pulses; n = 0;
    while (pulses == p0 && n < 500) begin tick(); n++; end
    repeat (5) tick();
    realign_hold("s5a");
    n = 0;
    while (!fail && n < 3000) begin tick(); n++; end
    check("s5b_in_fail", 32'(fail), 32'd1);
    realign_hold("s5b");
    pattern_ok = 1'b1;
    repeat (LOCK_LAT - 1 - RST_HOLD) tick();
    check("s5c_prelock", 32'(locked), 32'd0);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check("s5c_locked_blocked", 32'(locked), 32'd0);
    check("s5c_rn", 32'(div_resetn), 32'd0);
    bad = 0;
    for (int k = 1; k < LOCK_LAT; k++) begin
      tick();
      if (locked !== 1'b0) bad++;
    end
    check("s5c_no_early_lock", 32'(bad), 32'd0);
    tick();
    check("s5c_lock_after_restart", 32'(locked), 32'd1);

    // Scenario 6: async reset in the middle of a CALIB pulse
    do_reset(1'b0);
    n = 0;
    while (!div_calib && n < 500) begin tick(); n++; end
    check("s6_pulse_seen", 32'(div_calib), 32'd1);
    resetn = 1'b0;
    #1;
    check("s6_async_calib", 32'(div_calib), 32'd0);
    check("s6_async_rn", 32'(div_resetn), 32'd0);
    check("s6_async_busy", 32'(busy), 32'd1);
`ifdef CLKDIV_ALIGN_STATUS_EN
    check("s6_async_relock", 32'(relock_count), 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    pattern_ok = 1'b1;
    #1;
    repeat (LOCK_LAT - 1) tick();
    check("s6_restart_prelock", 32'(locked), 32'd0);
    tick();
    check("s6_restart_lock", 32'(locked), 32'd1);

    // Randomized traffic against the reference model
    do_reset(1'b1);
    m_reset();
    check("r_reset", 32'(outs), 32'(m_outs()));
    regime = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) regime = int'($urandom_range(0, 3));
      case (regime)
        0:       pattern_ok = 1'b1;
        1:       pattern_ok = 1'b0;
        2:       pattern_ok = ($urandom_range(0, 9) != 0);
        default: pattern_ok = 1'($urandom_range(0, 1));
      endcase
      realign = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      model_step(pattern_ok, realign);
      tick();
      check("r_outs", 32'(outs), 32'(m_outs()));
`ifdef CLKDIV_ALIGN_STATUS_EN
      check("r_calib_count", 32'(calib_count), 32'(m_tries));
      check("r_relock_count", 32'(relock_count), 32'(m_relock));
`endif
    end
    realign = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
